// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]           instr;
    logic [PKG_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: imem request/response channel, decoder handshake, redirect and debug state.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both high; the sender keeps
// its payload stable while valid && !ready. imem responses have no ready: the fetch stage always accepts them.
interface instruction_fetch_if #(
  parameter int ADDR_W = 32
);
  import fetch_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  fetch_state_t      dbg_state;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instruction, instr_pc, dbg_state,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instruction, instr_pc, dbg_state,
    output imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready, branch_taken, branch_target
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush; push on full is accepted when a pop happens the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_wdata,
  output fetch_entry_t     o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, credit-limited imem requests, prefetch FIFO and redirect drain.
// Defining FETCH_STATS_EN adds saturating stat_fetched / stat_dropped counters.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         stat_fetched,
  output logic [15:0]         stat_dropped
`endif
);

  localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN  = ~ADDR_W'(3);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;
  logic [CNT_W:0]    w_credits;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp;
  logic              w_keep;
  logic              w_pop;
  logic [ADDR_W-1:0] w_target;
  logic [CNT_W-1:0]  w_out_next;
  logic [CNT_W-1:0]  w_drop_next;

  // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
  assign w_credits    = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_req_valid  = (r_state != BOOT) && (w_credits < DEPTH_L);
  assign w_req_fire   = w_req_valid && bus.imem_req_ready;
  assign w_rsp        = bus.imem_rsp_valid && (r_state != BOOT);
  assign w_keep       = w_rsp && !bus.branch_taken && (r_drop_cnt == '0);
  assign w_pop        = !w_fifo_empty && bus.instr_ready;
  assign w_target     = bus.branch_target & ALIGN;
  assign w_out_next   = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp);
  assign w_push_entry = '{instr: bus.imem_rdata, pc: PKG_ADDR_W'(r_resp_pc)};

  // A redirect discards everything still owed by memory, including a request accepted this cycle.
  always_comb begin
    w_drop_next = r_drop_cnt;
    if (bus.branch_taken) begin
      w_drop_next = w_out_next;
    end else if (w_rsp && (r_drop_cnt != '0)) begin
      w_drop_next = r_drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC & ALIGN;
      r_resp_pc     <= RESET_PC & ALIGN;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_drop_next;
      if (bus.branch_taken) begin
        r_pc      <= w_target;
        r_resp_pc <= w_target;
      end else begin
        if (w_req_fire) r_pc      <= r_pc + ADDR_W'(4);
        if (w_keep)     r_resp_pc <= r_resp_pc + ADDR_W'(4);
      end
      case (r_state)
        BOOT:    r_state <= RUN;
        RUN:     if (bus.branch_taken && (w_drop_next != '0)) r_state <= DRAIN;
        DRAIN:   if (w_drop_next == '0) r_state <= RUN;
        default: r_state <= BOOT;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_flush (bus.branch_taken),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assert property (@(posedge clk) disable iff (reset) !(w_keep && w_fifo_full && !w_pop));

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_pc;
  assign bus.instr_valid    = !w_fifo_empty;
  assign bus.instruction    = w_fifo_empty ? NOP_INSTR : w_head.instr;
  assign bus.instr_pc       = w_fifo_empty ? '0 : ADDR_W'(w_head.pc);
  assign bus.dbg_state      = r_state;

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [15:0] r_stat_dropped;
  logic        w_drop_evt;

  assign w_drop_evt = w_rsp && !w_keep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_fetched <= '0;
      r_stat_dropped <= '0;
    end else begin
      if (w_pop && (r_stat_fetched != '1))      r_stat_fetched <= r_stat_fetched + 32'd1;
      if (w_drop_evt && (r_stat_dropped != '1)) r_stat_dropped <= r_stat_dropped + 16'd1;
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_dropped = r_stat_dropped;
`endif

endmodule
